ram_bank: RTL and testbench

Parametrised successor to the processor's 16×8 RAM: an addressable memory with its own memory-address register (MAR) and bus-side read/write. Replaces the switch-driven manual loader with a synchronous program-loader FSM fed through a valid/ready byte stream. It sits between the shared bus and the control sequencer, and also connects to the front-panel/UART program source.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_loader.sv | 77 +++++++
 rtl/ram_bank.sv | 91 +++++++++
 tb/tb_ram_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM bank: default widths and the loader state encoding.
package ram_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_RUN  = 2'd1,
    P_FULL = 2'd2
  } prog_state_t;

endpackage

// File: rtl/ram_loader.sv
// Program loader: accepts a valid/ready byte stream and turns it into
// memory writes at an auto-incrementing pointer.
module ram_loader
  import ram_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              program_mode,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_stop,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  prog_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              beat;

  // A beat leaving program mode is dropped rather than written.
  assign beat = (state == P_RUN) && prog_valid && program_mode;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= P_IDLE;
      ptr   <= '0;
      count <= '0;
    end else if (!program_mode) begin
      state <= P_IDLE;
    end else begin
      case (state)
        P_IDLE: begin
          if (prog_start) begin
            state <= P_RUN;
            ptr   <= prog_base;
            count <= '0;
          end
        end
        P_RUN: begin
          if (beat) begin
            ptr   <= ptr + ADDR_W'(1);
            count <= count + (ADDR_W + 1)'(1);
          end
          // Stop wins over going full; a concurrent beat is still written.
          if (prog_stop)                       state <= P_IDLE;
          else if (beat && count == LAST_COUNT) state <= P_FULL;
          else if (prog_start && !beat)         state <= P_IDLE;
        end
        P_FULL: begin
          if (prog_stop) state <= P_IDLE;
        end
        default: state <= P_IDLE;
      endcase
    end
  end

  assign prog_ready = (state == P_RUN);
  assign prog_done  = (state == P_FULL);
  assign prog_count = count;
  assign wr_en      = beat;
  assign wr_addr    = ptr;
  assign wr_data    = prog_data;

endmodule

// File: rtl/ram_bank.sv
// Addressable RAM with its own MAR, bus-side read/write and a streaming
// program loader that owns the write port while program_mode is high.
module ram_bank
  import ram_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              program_mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_en,
  input  logic              addr_inc,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dataout_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  input  logic              prog_stop,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar;

  logic              ld_wr_en;
  logic [ADDR_W-1:0] ld_wr_addr;
  logic [DATA_W-1:0] ld_wr_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_loader (
    .clk          (clk),
    .clr          (clr),
    .program_mode (program_mode),
    .prog_start   (prog_start),
    .prog_base    (prog_base),
    .prog_valid   (prog_valid),
    .prog_data    (prog_data),
    .prog_stop    (prog_stop),
    .prog_ready   (prog_ready),
    .prog_done    (prog_done),
    .prog_count   (prog_count),
    .wr_en        (ld_wr_en),
    .wr_addr      (ld_wr_addr),
    .wr_data      (ld_wr_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      mar <= '0;
    end else if (!program_mode) begin
      if (addr_en)       mar <= addr_in;
      else if (addr_inc) mar <= mar + ADDR_W'(1);
    end
  end

  // Bus writes use the pre-edge MAR, so a same-cycle MAR update does not move them.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mar;
    wr_data = data_in;
    if (program_mode) begin
      wr_en   = ld_wr_en;
      wr_addr = ld_wr_addr;
      wr_data = ld_wr_data;
    end else begin
      wr_en   = load;
    end
    if (clr) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign data_out = mem[mar];
  assign data_oe  = dataout_en & ~program_mode;

endmodule

// File: tb/tb_ram_bank.sv
// Directed scoreboard bench for ram_bank: run-mode bus access, MAR wrap,
// loader bursts, full memory, abort and reset mid-session.
module tb_ram_bank;
  import ram_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              clr, program_mode, addr_en, addr_inc, load, dataout_en;
  logic [ADDR_W-1:0] addr_in, prog_base;
  logic [DATA_W-1:0] data_in, prog_data, data_out;
  logic              data_oe, prog_start, prog_valid, prog_ready, prog_stop, prog_done;
  logic [ADDR_W:0]   prog_count;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .clr          (clr),
    .program_mode (program_mode),
    .addr_in      (addr_in),
    .addr_en      (addr_en),
    .addr_inc     (addr_inc),
    .load         (load),
    .data_in      (data_in),
    .dataout_en   (dataout_en),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .prog_start   (prog_start),
    .prog_base    (prog_base),
    .prog_valid   (prog_valid),
    .prog_data    (prog_data),
    .prog_ready   (prog_ready),
    .prog_stop    (prog_stop),
    .prog_done    (prog_done),
    .prog_count   (prog_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One run-mode bus cycle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic en, input logic inc,
                               input logic ld, input logic [DATA_W-1:0] d);
    addr_in  = a;
    addr_en  = en;
    addr_inc = inc;
    load     = ld;
    data_in  = d;
    tick();
    addr_en  = 1'b0;
    addr_inc = 1'b0;
    load     = 1'b0;
  endtask

  task automatic readAddr(input logic [ADDR_W-1:0] a);
    program_mode = 1'b0;
    applyStimulus(a, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput(data_out);
  endtask

  task automatic startSession(input logic [ADDR_W-1:0] base);
    program_mode = 1'b1;
    prog_base    = base;
    prog_start   = 1'b1;
    tick();
    prog_start   = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d);
    prog_valid = 1'b1;
    prog_data  = d;
    tick();
    prog_valid = 1'b0;
  endtask

  initial begin
    clr = 1'b1; program_mode = 1'b0; addr_en = 1'b0; addr_inc = 1'b0; load = 1'b0;
    dataout_en = 1'b0; addr_in = '0; prog_base = '0; data_in = '0; prog_data = '0;
    prog_start = 1'b0; prog_valid = 1'b0; prog_stop = 1'b0;
    tick();
    tick();
    clr = 1'b0;

    // Reset state
    expectVal("rst_mar", 0);          checkOutput(dut.mar);
    expectVal("rst_ready", 0);        checkOutput(prog_ready);
    expectVal("rst_done", 0);         checkOutput(prog_done);
    expectVal("rst_count", 0);        checkOutput(prog_count);
    expectVal("rst_state", P_IDLE);   checkOutput(dut.u_loader.state);
    expectVal("rst_oe", 0);           checkOutput(data_oe);

    // Run-mode write and read
    applyStimulus(4'd5, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 8'hA7);
    dataout_en = 1'b1; #1;
    expectVal("run_read", 8'hA7);     checkOutput(data_out);
    expectVal("run_oe", 1);           checkOutput(data_oe);
    program_mode = 1'b1; #1;
    expectVal("prog_oe_off", 0);      checkOutput(data_oe);
    program_mode = 1'b0; dataout_en = 1'b0; #1;

    // MAR wrap and write-before-increment
    applyStimulus(4'd15, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 8'h00);
    expectVal("mar_wrap", 0);         checkOutput(dut.mar);
    applyStimulus(4'd4, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 8'h44);
    applyStimulus(4'd3, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 8'h3C);
    expectVal("mar_inc", 4);          checkOutput(dut.mar);
    expectVal("addr4_kept", 8'h44);   checkOutput(data_out);
    expectVal("addr3_written", 8'h3C); readAddr(4'd3);

    // Loader burst wrapping past the top address
    startSession(4'd14);
    expectVal("burst_ready", 1);      checkOutput(prog_ready);
    expectVal("burst_count0", 0);     checkOutput(prog_count);
    prog_valid = 1'b1;
    prog_data = 8'h11; tick();
    prog_data = 8'h22; tick();
    prog_data = 8'h33; tick();
    prog_valid = 1'b0;
    expectVal("burst_count", 3);      checkOutput(prog_count);
    expectVal("burst_done", 0);       checkOutput(prog_done);
    prog_stop = 1'b1; tick(); prog_stop = 1'b0;
    expectVal("burst_idle", 0);       checkOutput(prog_ready);
    expectVal("burst_hold", 3);       checkOutput(prog_count);
    expectVal("mem14", 8'h11);        readAddr(4'd14);
    expectVal("mem15", 8'h22);        readAddr(4'd15);
    expectVal("mem0", 8'h33);         readAddr(4'd0);

    // Full memory with valid held high
    startSession(4'd0);
    prog_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_data = 8'(8'h80 + i);
      expectVal($sformatf("full_ready%0d", i), 1); checkOutput(prog_ready);
      tick();
    end
    expectVal("full_done", 1);        checkOutput(prog_done);
    expectVal("full_ready_off", 0);   checkOutput(prog_ready);
    expectVal("full_count", 16);      checkOutput(prog_count);
    prog_data = 8'hEE; tick();
    expectVal("full_17th_count", 16); checkOutput(prog_count);
    prog_valid = 1'b0;
    prog_stop = 1'b1; tick(); prog_stop = 1'b0;
    expectVal("full_cleared", 0);     checkOutput(prog_done);
    expectVal("full_mem0", 8'h80);    readAddr(4'd0);
    expectVal("full_mem15", 8'h8F);   readAddr(4'd15);

    // Abort by dropping program_mode with a beat pending
    startSession(4'd8);
    beat(8'hA1);
    beat(8'hA2);
    prog_valid = 1'b1; prog_data = 8'hA3; program_mode = 1'b0;
    tick();
    prog_valid = 1'b0;
    expectVal("abort_state", P_IDLE); checkOutput(dut.u_loader.state);
    expectVal("abort_count", 2);      checkOutput(prog_count);
    expectVal("abort_mem8", 8'hA1);   readAddr(4'd8);
    expectVal("abort_mem9", 8'hA2);   readAddr(4'd9);
    expectVal("abort_mem10", 8'h8A);  readAddr(4'd10);

    // Reset in the middle of a session
    applyStimulus(4'd7, 1'b1, 1'b0, 1'b0, 8'h00);
    startSession(4'd4);
    for (int i = 0; i < 4; i++) beat(8'(8'hB0 + i));
    clr = 1'b1; tick(); clr = 1'b0;
    expectVal("clr_ready", 0);        checkOutput(prog_ready);
    expectVal("clr_count", 0);        checkOutput(prog_count);
    expectVal("clr_mar", 0);          checkOutput(dut.mar);
    for (int i = 0; i < 4; i++) begin
      expectVal($sformatf("clr_mem%0d", 4 + i), 8'(8'hB0 + i));
      readAddr(4'(4 + i));
    end

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
